tictactoe_game_ctrl: RTL

//  Game-state controller directly upstream of DetectWinner. Accepts player moves over a valid/ready

---
 rtl/tictactoe_pkg.sv | 38 +++
 rtl/tictactoe_game_ctrl_if.sv | 28 ++
 rtl/DetectWinner.sv | 32 +++
 rtl/tictactoe_move_check.sv | 30 +++
 rtl/tictactoe_game_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// ---------------------------------------------------------------------------
// tictactoe_pkg
// Shared definitions for the tic-tac-toe game controller and DetectWinner:
// board geometry, move-position width, winner codes and the controller state
// encoding. Also provides a cell counter used by the board invariants.
// Board bit n = cell n (8 = top-left ... 0 = bottom-right).
// ---------------------------------------------------------------------------
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;
  localparam int POS_W     = 4;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WIN   = 2'b10,
    ST_DRAW  = 2'b11
  } state_e;

  // Number of occupied cells on a board (0..9).
  function automatic logic [3:0] cell_count(input logic [NUM_CELLS-1:0] cells);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      n = n + 4'(cells[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tictactoe_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// tictactoe_game_ctrl_if
// Move request channel into the game controller (valid/ready handshake).
//   move_valid  requester -> controller  move request present
//   move_pos    requester -> controller  target cell 0..8 (9..15 illegal)
//   move_ready  controller -> requester  controller can take a move
// master = move requester, slave = game controller.
// ---------------------------------------------------------------------------
interface tictactoe_game_ctrl_if;
  import tictactoe_pkg::*;

  logic             move_valid;
  logic [POS_W-1:0] move_pos;
  logic             move_ready;

  modport master (
    output move_valid,
    output move_pos,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_pos,
    output move_ready
  );

endinterface

// File: rtl/DetectWinner.sv
// ---------------------------------------------------------------------------
// DetectWinner
// Combinational three-in-a-row detector over two occupancy boards.
//   ain       in   9  first player's board (X)
//   bin       in   9  second player's board (O)
//   win_line  out  8  one bit per line complete on either board:
//     [0] top row 8-7-6     [1] middle row 5-4-3  [2] bottom row 2-1-0
//     [3] left col 8-5-2    [4] middle col 7-4-1  [5] right col 6-3-0
//     [6] diagonal 8-4-0    [7] diagonal 6-4-2
// ---------------------------------------------------------------------------
module DetectWinner
  import tictactoe_pkg::*;
(
  input  logic [NUM_CELLS-1:0] ain,
  input  logic [NUM_CELLS-1:0] bin,
  output logic [NUM_LINES-1:0] win_line
);

  function automatic logic [NUM_LINES-1:0] lines_of(input logic [NUM_CELLS-1:0] b);
    return {b[6] & b[4] & b[2],
            b[8] & b[4] & b[0],
            b[6] & b[3] & b[0],
            b[7] & b[4] & b[1],
            b[8] & b[5] & b[2],
            b[2] & b[1] & b[0],
            b[5] & b[4] & b[3],
            b[8] & b[7] & b[6]};
  endfunction

  assign win_line = lines_of(ain) | lines_of(bin);

endmodule

// File: rtl/tictactoe_move_check.sv
// ---------------------------------------------------------------------------
// tictactoe_move_check
// Combinational move decoder: turns a requested cell position into a one-hot
// cell mask and flags whether the move is legal (in range and cell empty).
//   move_pos   in   target cell 0..8; 9..15 are out of range
//   occupied   in   union of both players' boards
//   cell_mask  out  one-hot mask of the target cell, 0 when out of range
//   legal      out  1 when the cell exists and is empty
// ---------------------------------------------------------------------------
module tictactoe_move_check
  import tictactoe_pkg::*;
(
  input  logic [POS_W-1:0]     move_pos,
  input  logic [NUM_CELLS-1:0] occupied,
  output logic [NUM_CELLS-1:0] cell_mask,
  output logic                 legal
);

  logic in_range;

  always_comb begin
    in_range  = (move_pos < POS_W'(NUM_CELLS));
    cell_mask = '0;
    if (in_range) begin
      cell_mask = NUM_CELLS'(1) << move_pos;
    end
    legal = in_range && ((cell_mask & occupied) == '0);
  end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// ---------------------------------------------------------------------------
// tictactoe_game_ctrl
// Game-state controller sitting in front of DetectWinner. Takes moves over a
// valid/ready channel, rejects illegal ones, alternates X/O, holds both
// occupancy boards and ends the game on a win or a full board.
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   new_game    in   synchronous restart, same effect as reset
//   mv_if       slave modport: move_valid / move_pos in, move_ready out
//   xboard      out  X occupancy (DetectWinner ain)
//   oboard      out  O occupancy (DetectWinner bin)
//   win_line    in   DetectWinner result on xboard/oboard
//   turn_o      out  0 = X to move, 1 = O to move
//   move_count  out  legal moves accepted this game (0..9)
//   illegal     out  one-cycle pulse after a rejected handshake
//   game_over   out  high in WIN and DRAW
//   winner      out  00 none, 01 X, 10 O, 11 draw
//   win_line_q  out  win_line captured when the game was won, else 0
// Each accepted move spends one cycle in CHECK so that win_line is evaluated
// on the registered boards; the turn only flips when play continues.
// ---------------------------------------------------------------------------
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  tictactoe_game_ctrl_if.slave   mv_if,
  output logic [NUM_CELLS-1:0]   xboard,
  output logic [NUM_CELLS-1:0]   oboard,
  input  logic [NUM_LINES-1:0]   win_line,
  output logic                   turn_o,
  output logic [3:0]             move_count,
  output logic                   illegal,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [NUM_LINES-1:0]   win_line_q
);

  state_e               state_q,      state_d;
  logic [NUM_CELLS-1:0] xboard_q,     xboard_d;
  logic [NUM_CELLS-1:0] oboard_q,     oboard_d;
  logic                 turn_o_q,     turn_o_d;
  logic [3:0]           move_count_q, move_count_d;
  logic                 illegal_q,    illegal_d;
  logic                 game_over_q,  game_over_d;
  winner_e              winner_q,     winner_d;
  logic [NUM_LINES-1:0] win_latch_q,  win_latch_d;
  logic                 move_ready_q, move_ready_d;

  logic [NUM_CELLS-1:0] cell_mask;
  logic                 move_legal;
  logic                 handshake;

  tictactoe_move_check u_move_check (
    .move_pos  (mv_if.move_pos),
    .occupied  (xboard_q | oboard_q),
    .cell_mask (cell_mask),
    .legal     (move_legal)
  );

  // move_ready_q is high exactly when the state is PLAY.
  assign handshake = mv_if.move_valid & move_ready_q;

  always_comb begin
    state_d      = state_q;
    xboard_d     = xboard_q;
    oboard_d     = oboard_q;
    turn_o_d     = turn_o_q;
    move_count_d = move_count_q;
    illegal_d    = 1'b0;
    winner_d     = winner_q;
    win_latch_d  = win_latch_q;

    if (new_game) begin
      // Restart wins over any handshake presented in the same cycle.
      state_d      = ST_PLAY;
      xboard_d     = '0;
      oboard_d     = '0;
      turn_o_d     = FIRST_PLAYER;
      move_count_d = '0;
      winner_d     = WIN_NONE;
      win_latch_d  = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (handshake) begin
            if (move_legal) begin
              if (turn_o_q) begin
                oboard_d = oboard_q | cell_mask;
              end else begin
                xboard_d = xboard_q | cell_mask;
              end
              move_count_d = move_count_q + 4'd1;
              state_d      = ST_CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // A win is tested before the full-board test so a winning
          // ninth move is reported as a win.
          if (win_line != '0) begin
            state_d     = ST_WIN;
            winner_d    = turn_o_q ? WIN_O : WIN_X;
            win_latch_d = win_line;
          end else if (move_count_q == 4'(NUM_CELLS)) begin
            state_d  = ST_DRAW;
            winner_d = WIN_DRAW;
          end else begin
            state_d  = ST_PLAY;
            turn_o_d = ~turn_o_q;
          end
        end
        default: begin
          // WIN and DRAW hold everything until restart.
        end
      endcase
    end

    move_ready_d = (state_d == ST_PLAY);
    game_over_d  = (state_d == ST_WIN) || (state_d == ST_DRAW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      xboard_q     <= '0;
      oboard_q     <= '0;
      turn_o_q     <= FIRST_PLAYER;
      move_count_q <= '0;
      illegal_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= WIN_NONE;
      win_latch_q  <= '0;
      move_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      xboard_q     <= xboard_d;
      oboard_q     <= oboard_d;
      turn_o_q     <= turn_o_d;
      move_count_q <= move_count_d;
      illegal_q    <= illegal_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      win_latch_q  <= win_latch_d;
      move_ready_q <= move_ready_d;
    end
  end

  assign mv_if.move_ready = move_ready_q;
  assign xboard           = xboard_q;
  assign oboard           = oboard_q;
  assign turn_o           = turn_o_q;
  assign move_count       = move_count_q;
  assign illegal          = illegal_q;
  assign game_over        = game_over_q;
  assign winner           = winner_q;
  assign win_line_q       = win_latch_q;

  // A cell belongs to at most one player, and every occupied cell is a
  // counted move.
  a_no_overlap : assert property (@(posedge clk) disable iff (reset)
    (xboard_q & oboard_q) == '0);
  a_count_match : assert property (@(posedge clk) disable iff (reset)
    cell_count(xboard_q | oboard_q) == move_count_q);

endmodule
